// File: rtl/vec_lsu_pkg.sv
// vec_pkg: vector memory constants, vector type and LSU state encoding
// shared by the LSU, mem_control and the vector register file.
package vec_pkg;
  localparam int ADDR_W = 18;
  localparam int LANES = 16;
  localparam int LANE_W = 16;
  localparam int RD_LAT = 2;
  localparam int LEN_W = 3;
  localparam int CNT_W = LEN_W + 1;
  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/vec_lsu_if.sv
// vec_lsu_if: request, memory and response signals of the vector LSU;
// slave is the LSU view, master is the execute/memory environment view.
interface vec_lsu_if;
  import vec_pkg::*;
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  vec_t req_wdata;
  vec_t mem_data, mem_q;
  logic [ADDR_W-1:0] mem_address;
  logic mem_wren;
  logic resp_valid, resp_ready, resp_last, busy;
  vec_t resp_data;
  modport slave (
    input req_valid, req_we, req_addr, req_len, req_wdata, mem_q, resp_ready,
    output req_ready, mem_data, mem_address, mem_wren, resp_valid, resp_data, resp_last, busy
  );
  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, mem_q, resp_ready,
    input req_ready, mem_data, mem_address, mem_wren, resp_valid, resp_data, resp_last, busy
  );
endinterface

// File: rtl/vec_lsu_beat_ctr.sv
// lsu_beat_ctr: loadable down-counter with zero/one flags.
module lsu_beat_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o,
  output logic         one_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : dec_i ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
  assign one_o = cnt_q == W'(1);
endmodule

// File: rtl/vec_lsu.sv
// vec_lsu: vector load/store unit in front of mem_control; single-vector
// stores, 1-8 beat load bursts returned over a valid/ready response port.
module vec_lsu
  import vec_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  vec_lsu_if.slave  bus
);
  lsu_state_t state_q, state_d;
  logic init_q, we_q, we_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  vec_t wdata_q, wdata_d, rdata_q, rdata_d;
  logic acc, beat_one, lat_zero, beat_zero_unused, lat_one_unused;
  logic [CNT_W-1:0] beat_val;
  assign bus.req_ready = state_q == IDLE && init_q;
  assign acc = bus.req_valid && bus.req_ready;
  assign bus.busy = state_q != IDLE;
  assign bus.mem_wren = state_q == ISSUE && we_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data = wdata_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_data = rdata_q;
  assign bus.resp_last = rlast_q;
  assign beat_val = bus.req_we ? CNT_W'(1) : {1'b0, bus.req_len} + 1'b1;
  lsu_beat_ctr #(.W(CNT_W)) u_beats (
    .clk(clk), .rst_n(rst_n), .load_i(acc),
    .dec_i(state_q == RESP && bus.resp_ready), .val_i(beat_val),
    .zero_o(beat_zero_unused), .one_o(beat_one)
  );
  lsu_beat_ctr #(.W(CNT_W)) u_lat (
    .clk(clk), .rst_n(rst_n), .load_i(state_q == ISSUE),
    .dec_i(state_q == WAIT && !lat_zero), .val_i(CNT_W'(RD_LAT - 1)),
    .zero_o(lat_zero), .one_o(lat_one_unused)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    rdata_d = rdata_q;
    rvalid_d = rvalid_q;
    rlast_d = rlast_q;
    case (state_q)
      IDLE: if (acc) begin
        addr_d = bus.req_addr;
        wdata_d = bus.req_wdata;
        we_d = bus.req_we;
        state_d = ISSUE;
      end
      ISSUE: state_d = we_q ? IDLE : WAIT;
      WAIT: if (lat_zero) begin
        rdata_d = bus.mem_q;
        rvalid_d = 1'b1;
        rlast_d = beat_one;
        state_d = RESP;
      end
      RESP: if (bus.resp_ready) begin
        rvalid_d = 1'b0;
        rlast_d = 1'b0;
        state_d = beat_one ? IDLE : ISSUE;
        addr_d = beat_one ? addr_q : addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      init_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q <= 1'b1;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
    end
endmodule

// File: tb/tb_vec_lsu.sv
// tb_vec_lsu: random and directed requests against a transaction-level
// reference memory; checks data, last flags, beat timing and wren pulses.
module tb_vec_lsu;
  import vec_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, e0 = 0, n_cmp = 0, n_err = 0, n_wr = 0, n_st = 0, wn = 0;
  vec_t ref_mem[int];
  logic [ADDR_W-1:0] wa[256];
  vec_t wd[256];
  vec_t rd1, q;
  vec_lsu_if bus();
  vec_lsu dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.mem_wren) n_wr <= n_wr + 1;
  function automatic vec_t pat(input logic [ADDR_W-1:0] a);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = a[15:0] ^ {a[17:16], 10'h0, 4'(k)};
    return v;
  endfunction
  function automatic vec_t mem_rd(input logic [ADDR_W-1:0] a);
    vec_t v = pat(a);
    for (int j = 0; j < wn; j++) if (wa[j] == a) v = wd[j];
    return v;
  endfunction
  function automatic vec_t ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction
  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = 16'($urandom);
    return v;
  endfunction
  // Memory model with a two-stage read pipeline, i.e. RD_LAT edges.
  always @(posedge clk) begin
    if (bus.mem_wren) begin
      wa[wn[7:0]] <= bus.mem_address;
      wd[wn[7:0]] <= bus.mem_data;
      wn <= wn + 1;
    end
    rd1 <= mem_rd(bus.mem_address);
    q <= rd1;
  end
  assign bus.mem_q = q;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len, input vec_t d);
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_len = len;
    bus.req_wdata = d;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_wdata = rnd_vec();
    e0 = cyc;
  endtask
  task automatic wait_valid(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!bus.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = bus.resp_valid;
  endtask
  task automatic store_op(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len, input vec_t d);
    do_req(1'b1, a, len, d);
    chk("st_wren", bus.mem_wren, 1);
    chk("st_addr", bus.mem_address, a);
    chk("st_data", bus.mem_data, d);
    chk("st_noresp", bus.resp_valid, 0);
    ref_mem[int'(a)] = d;
    n_st++;
    @(posedge clk);
    #1 chk("st_wren_off", bus.mem_wren, 0);
    chk("st_idle", bus.busy, 0);
  endtask
  task automatic load_op(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len, input int stall_beat, input int stall_n);
    int last;
    bit ok;
    vec_t held;
    logic [ADDR_W-1:0] ea;
    do_req(1'b0, a, len, rnd_vec());
    last = e0;
    for (int i = 0; i <= int'(len); i++) begin
      wait_valid(ok);
      if (!ok) begin
        chk("resp_timeout", 0, 1);
        return;
      end
      ea = a + ADDR_W'(i);
      chk("beat_gap", cyc - last, 3);
      chk("resp_data", bus.resp_data, ref_rd(ea));
      chk("resp_last", bus.resp_last, i == int'(len));
      chk("beat_addr", bus.mem_address, ea);
      chk("busy_rdy", {bus.busy, bus.req_ready}, 2'b10);
      if (i == stall_beat) begin
        held = bus.resp_data;
        repeat (stall_n) begin
          @(negedge clk);
          chk("stall_valid", bus.resp_valid, 1);
          chk("stall_data", bus.resp_data, held);
          chk("stall_addr", bus.mem_address, ea);
        end
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
      last = cyc;
    end
    @(negedge clk);
    chk("resp_drop", bus.resp_valid, 0);
    chk("end_idle", bus.busy, 0);
  endtask
  task automatic chk_cleared(input string tag);
    chk(tag, {bus.mem_wren, bus.resp_valid, bus.resp_last, bus.busy, bus.req_ready}, 0);
    chk({tag, "_addr"}, bus.mem_address, 0);
    chk({tag, "_data"}, bus.mem_data | bus.resp_data, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    bit ok;
    int hits;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_cleared("rst_out");
    end
    rst_n = 1'b1;
    #1 chk("rdy_first", bus.req_ready, 0);
    @(posedge clk);
    #1 chk("rdy_after", bus.req_ready, 1);
    chk("busy_after", bus.busy, 0);
    for (int k = 0; k < LANES; k++) v[k] = 16'h0001;
    store_op(18'h00005, 3'd3, v);
    load_op(18'h00005, 3'd0, 99, 0);
    for (int k = 0; k < LANES; k++) v[k] = 16'(k);
    store_op(18'h00010, 3'd0, v);
    load_op(18'h00010, 3'd0, 99, 0);
    load_op(18'h3FFFE, 3'd3, 99, 0);
    load_op(18'h00100, 3'd1, 0, 10);
    do_req(1'b0, 18'h00200, 3'd3, rnd_vec());
    wait_valid(ok);
    chk("abort_beat1", bus.resp_valid, 1);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_cleared("abort_out");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      hits += int'(bus.resp_valid);
    end
    bus.resp_ready = 1'b0;
    chk("abort_noresp", hits, 0);
    load_op(18'h00200, 3'd1, 99, 0);
    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      logic [LEN_W-1:0] len;
      a = ($urandom_range(0, 1) == 1) ? 18'h3FFF8 + ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, 15));
      len = LEN_W'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) store_op(a, len, rnd_vec());
      else load_op(a, len, $urandom_range(0, int'(len) + 2), $urandom_range(1, 6));
    end
    @(negedge clk);
    chk("wr_count", n_wr, n_st);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
